// File: rtl/cram_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : cram_pkg                                                     |
// | Description : Shared types and constants for the cartridge-side C64 DMA   |
// |               master (cram_dma) and its PHI2 phase tracker.                |
// |               - state_t : transfer state machine encoding                 |
// |               - S_ADDR / S_DDRV / S_SAMP : PHI2 phase points (DotClk      |
// |                 counts after the PHI2 falling edge, first cycle = 1)      |
// |               - RADDR_W_DEF : default cartridge DRAM byte address width   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package cram_pkg;

  // Cartridge DRAM address is {Block[7:0], Window[5:0], A[7:0]}.
  localparam int RADDR_W_DEF    = 22;
  localparam int SETTLE_CYC_DEF = 3;

  // Phase points inside one PHI2 cycle (8 DotClk per PHI2 gives S = 1..8).
  localparam logic [3:0] S_ADDR = 4'd1;   // address / R/W driven from here
  localparam logic [3:0] S_DDRV = 4'd5;   // write data driven from here
  localparam logic [3:0] S_SAMP = 4'd7;   // read data sampled here
  localparam logic [3:0] S_MAX  = 4'd15;  // saturation value of S

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    PREFETCH = 3'd2,
    BUS      = 3'd3,
    RAMWR    = 3'd4,
    FINISH   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cram_phi2_phase.sv
// +----------------------------------------------------------------------------+
// | Module      : cram_phi2_phase                                              |
// | Description : Tracks the position inside the C64 PHI2 cycle, measured in  |
// |               DotClk cycles. S is 1 in the DotClk cycle right after a    |
// |               PHI2 falling edge, then counts up and saturates at 15.      |
// |               S stays 0 until the first falling edge after reset.         |
// | Ports       : clk   in  DotClk                                             |
// |               rst   in  asynchronous active-high reset                     |
// |               phi2  in  C64 PHI2 (asynchronous, sampled on clk)            |
// |               s     out current phase count                                |
// |               fall  out PHI2 falling edge seen this cycle (S becomes 1)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cram_phi2_phase
  import cram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       phi2,
  output logic [3:0] s,
  output logic       fall
);

  logic       phi2_q, phi2_d;
  logic [3:0] s_q, s_d;

  always_comb begin
    phi2_d = phi2;
    fall   = phi2_q & ~phi2;
    s_d    = s_q;
    if (fall) begin
      s_d = S_ADDR;
    end else if ((s_q != 4'd0) && (s_q != S_MAX)) begin
      // S = 0 means "not yet synchronised"; it only leaves 0 on a falling edge.
      s_d = s_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi2_q <= 1'b0;
      s_q    <= 4'd0;
    end else begin
      phi2_q <= phi2_d;
      s_q    <= s_d;
    end
  end

  assign s = s_q;

endmodule

`default_nettype wire

// File: rtl/cram_dma.sv
// +----------------------------------------------------------------------------+
// | Module      : cram_dma                                                     |
// | Description : Cartridge-side C64 expansion-port bus master. Pulls nDMA,   |
// |               takes the C64 bus and moves a block of bytes between C64   |
// |               memory and cartridge DRAM, one byte per PHI2 cycle. DRAM is |
// |               reached through a req/ack byte port.                        |
// | Ports       : DotClk/RES         clock (8x PHI2) / async active-high reset|
// |               PHI2, BA           C64 phase-2 clock, VIC bus-available     |
// |               start,dir,c64_addr,ram_base,len   transfer setup            |
// |               busy, done         status                                   |
// |               nDMA               open-drain DMA request (0 or Z)          |
// |               A_*, RnW_*, D_*    C64 bus drivers / data input             |
// |               ram_*              DRAM byte port                           |
// | Option      : CRAM_DMA_IRQ_EN adds nIRQ_out (open-drain, asserted from   |
// |               done until irq_ack) and irq_ack.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cram_dma
  import cram_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int RADDR_W    = RADDR_W_DEF
) (
  input  logic               DotClk,
  input  logic               RES,
  input  logic               PHI2,
  input  logic               BA,
  input  logic               start,
  input  logic               dir,
  input  logic [15:0]        c64_addr,
  input  logic [RADDR_W-1:0] ram_base,
  input  logic [15:0]        len,
  output logic               busy,
  output logic               done,
  output wire                nDMA,
`ifdef CRAM_DMA_IRQ_EN
  output wire                nIRQ_out,
  input  logic               irq_ack,
`endif
  output logic [15:0]        A_out,
  output logic               A_oe,
  output logic               RnW_out,
  output logic               RnW_oe,
  output logic [7:0]         D_out,
  output logic               D_oe,
  input  logic [7:0]         D_in,
  output logic               ram_req,
  output logic               ram_we,
  output logic [RADDR_W-1:0] ram_addr,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata,
  input  logic               ram_ack
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);

  logic [3:0] s;
  logic       fall;

  cram_phi2_phase u_phase (
    .clk  (DotClk),
    .rst  (RES),
    .phi2 (PHI2),
    .s    (s),
    .fall (fall)
  );

  state_t             state_q, state_d;
  logic [15:0]        c64_addr_q, c64_addr_d;
  logic [RADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [16:0]        remaining_q, remaining_d;   // 17 bits so len=0 can mean 65536
  logic               dir_q, dir_d;
  logic [7:0]         hold_q, hold_d;
  logic               active_q, active_d;          // current PHI2 cycle is driven
  logic [SCW-1:0]     settle_q, settle_d;

  logic w_last;
  logic w_bus_on;

  assign w_last = (remaining_q == 17'd1);

  // The bus cycle is claimed combinationally at S_ADDR so the address appears
  // in the very first DotClk of the PHI2 cycle; active_q then holds it to the
  // next falling edge regardless of later BA changes.
  assign w_bus_on = (state_q == BUS) && (active_q || ((s == S_ADDR) && BA));

  always_comb begin
    state_d     = state_q;
    c64_addr_d  = c64_addr_q;
    ram_addr_d  = ram_addr_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    hold_d      = hold_q;
    active_d    = active_q;
    settle_d    = settle_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          c64_addr_d  = c64_addr;
          ram_addr_d  = ram_base;
          dir_d       = dir;
          remaining_d = (len == 16'd0) ? 17'h10000 : {1'b0, len};
          settle_d    = '0;
          active_d    = 1'b0;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        if (fall) begin
          if (settle_q == SCW'(SETTLE_CYC - 1)) begin
            state_d = dir_q ? PREFETCH : BUS;
          end else begin
            settle_d = settle_q + SCW'(1);
          end
        end
      end

      PREFETCH: begin
        if (ram_ack) begin
          hold_d  = ram_rdata;
          state_d = BUS;
        end
      end

      BUS: begin
        if (!active_q) begin
          // BA low at S_ADDR: give this PHI2 cycle to the VIC and retry.
          if ((s == S_ADDR) && BA) begin
            active_d = 1'b1;
          end
        end else begin
          if (!dir_q && (s == S_SAMP)) begin
            hold_d = D_in;
          end
          if (fall) begin
            active_d = 1'b0;
            if (dir_q) begin
              c64_addr_d  = c64_addr_q + 16'd1;
              ram_addr_d  = ram_addr_q + RADDR_W'(1);
              remaining_d = remaining_q - 17'd1;
              state_d     = w_last ? FINISH : PREFETCH;
            end else begin
              state_d = RAMWR;
            end
          end
        end
      end

      RAMWR: begin
        if (ram_ack) begin
          c64_addr_d  = c64_addr_q + 16'd1;
          ram_addr_d  = ram_addr_q + RADDR_W'(1);
          remaining_d = remaining_q - 17'd1;
          state_d     = w_last ? FINISH : BUS;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge DotClk or posedge RES) begin
    if (RES) begin
      state_q     <= IDLE;
      c64_addr_q  <= 16'd0;
      ram_addr_q  <= '0;
      remaining_q <= 17'd0;
      dir_q       <= 1'b0;
      hold_q      <= 8'd0;
      active_q    <= 1'b0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      c64_addr_q  <= c64_addr_d;
      ram_addr_q  <= ram_addr_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      hold_q      <= hold_d;
      active_q    <= active_d;
      settle_q    <= settle_d;
    end
  end

  // Outputs are decoded from registered state so an asynchronous RES
  // releases every driver immediately.
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign nDMA      = busy ? 1'b0 : 1'bz;

  assign A_oe      = w_bus_on;
  assign RnW_oe    = w_bus_on;
  assign A_out     = w_bus_on ? c64_addr_q : 16'd0;
  assign RnW_out   = w_bus_on ? ~dir_q : 1'b1;
  assign D_oe      = w_bus_on && dir_q && (s >= S_DDRV);
  assign D_out     = D_oe ? hold_q : 8'd0;

  assign ram_req   = (state_q == PREFETCH) || (state_q == RAMWR);
  assign ram_we    = (state_q == RAMWR);
  assign ram_addr  = ram_req ? ram_addr_q : '0;
  assign ram_wdata = ram_we ? hold_q : 8'd0;

`ifdef CRAM_DMA_IRQ_EN
  logic irq_q, irq_d;

  // done has priority so an acknowledge landing on the completion cycle
  // cannot swallow the interrupt.
  always_comb begin
    irq_d = irq_q;
    if (done) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge DotClk or posedge RES) begin
    if (RES) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign nIRQ_out = irq_q ? 1'b0 : 1'bz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cram_dma.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_cram_dma                                                  |
// | Description : Directed self-checking bench for cram_dma. Models C64       |
// |               memory (data derived from address), a DRAM responder with   |
// |               a 2-DotClk ack and pull-ups on the open-drain outputs.      |
// |               Optional IRQ checks are built when CRAM_DMA_IRQ_EN is set.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cram_dma;

  logic        DotClk   = 1'b0;
  logic        RES      = 1'b1;
  logic        PHI2     = 1'b1;
  logic        BA       = 1'b1;
  logic        start    = 1'b0;
  logic        dir      = 1'b0;
  logic [15:0] c64_addr = 16'd0;
  logic [21:0] ram_base = 22'd0;
  logic [15:0] len      = 16'd0;
  logic        busy, done;
  wire         nDMA;
  logic [15:0] A_out;
  logic        A_oe, RnW_out, RnW_oe, D_oe;
  logic [7:0]  D_out, D_in;
  logic        ram_req, ram_we;
  logic [21:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_ack  = 1'b0;
`ifdef CRAM_DMA_IRQ_EN
  wire         nIRQ_out;
  logic        irq_ack  = 1'b0;
  pullup (nIRQ_out);
`endif

  pullup (nDMA);

  cram_dma u_dut (
    .DotClk    (DotClk),
    .RES       (RES),
    .PHI2      (PHI2),
    .BA        (BA),
    .start     (start),
    .dir       (dir),
    .c64_addr  (c64_addr),
    .ram_base  (ram_base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .nDMA      (nDMA),
`ifdef CRAM_DMA_IRQ_EN
    .nIRQ_out  (nIRQ_out),
    .irq_ack   (irq_ack),
`endif
    .A_out     (A_out),
    .A_oe      (A_oe),
    .RnW_out   (RnW_out),
    .RnW_oe    (RnW_oe),
    .D_out     (D_out),
    .D_oe      (D_oe),
    .D_in      (D_in),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack)
  );

  // DotClk period 10; PHI2 toggles every 40 (8 DotClk per PHI2), on DotClk negedges.
  initial forever #5 DotClk = ~DotClk;
  initial forever #40 PHI2 = ~PHI2;

  // C64 memory: byte at address a is {n,n} with n = a[3:0]+1 (C000 -> 11, C001 -> 22 ...).
  function automatic logic [7:0] c64_byte(input logic [15:0] a);
    logic [3:0] n;
    n = a[3:0] + 4'd1;
    return {n, n};
  endfunction

  // DRAM contents.
  function automatic logic [7:0] ram_byte(input logic [21:0] a);
    case (a)
      22'h3FFFFE: return 8'hA5;
      22'h3FFFFF: return 8'h5A;
      22'h000000: return 8'hFF;
      default:    return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  assign D_in      = c64_byte(A_out);
  assign ram_rdata = ram_byte(ram_addr);

  // ---------------- monitors and DRAM responder ----------------
  int          bus_cnt = 0, doe_cnt = 0, doe_early = 0, done_cnt = 0, ndma_bad = 0;
  int          wr_cnt = 0, rd_cnt = 0, ram_unstable = 0, aoe_idx = 0, ram_wait = 0;
  logic [15:0] bus_addr [64];
  logic        bus_rnw  [64];
  logic [7:0]  bus_dout [64];
  logic [21:0] wr_addr  [64];
  logic [7:0]  wr_data  [64];
  logic [21:0] rd_addr  [64];
  logic        prev_aoe = 1'b0, prev_req = 1'b0, req_we = 1'b0;
  logic [21:0] req_addr = 22'd0;
  logic [7:0]  req_wdata = 8'd0;

  always @(negedge DotClk) begin
    if (A_oe) begin
      if (!prev_aoe) begin
        if (bus_cnt < 64) begin
          bus_addr[bus_cnt] = A_out;
          bus_rnw[bus_cnt]  = RnW_out;
        end
        bus_cnt++;
        aoe_idx = 1;
      end else begin
        aoe_idx++;
      end
    end else begin
      aoe_idx = 0;
    end
    if (D_oe) begin
      doe_cnt++;
      if (!A_oe || aoe_idx < 5 || aoe_idx > 8) doe_early++;
      if (bus_cnt > 0 && bus_cnt <= 64) bus_dout[bus_cnt-1] = D_out;
    end
    prev_aoe = A_oe;
    if (done) done_cnt++;
    if (busy ? (nDMA !== 1'b0) : (nDMA !== 1'b1)) ndma_bad++;
    if (ram_req && prev_req &&
        (ram_addr !== req_addr || ram_we !== req_we || ram_wdata !== req_wdata))
      ram_unstable++;
    if (ram_req && !prev_req) begin
      req_addr  = ram_addr;
      req_we    = ram_we;
      req_wdata = ram_wdata;
    end
    prev_req = ram_req;
    if (ram_ack) begin
      ram_ack  = 1'b0;
      ram_wait = 0;
    end else if (ram_req) begin
      ram_wait++;
      if (ram_wait == 2) begin
        ram_ack = 1'b1;
        if (ram_we) begin
          if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = ram_addr;
            wr_data[wr_cnt] = ram_wdata;
          end
          wr_cnt++;
        end else begin
          if (rd_cnt < 64) rd_addr[rd_cnt] = ram_addr;
          rd_cnt++;
        end
      end
    end else begin
      ram_wait = 0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge DotClk);
    #1;
  endtask

  task automatic start_xfer(input logic d, input logic [15:0] ca,
                            input logic [21:0] rb, input logic [15:0] ln);
    dir      = d;
    c64_addr = ca;
    ram_base = rb;
    len      = ln;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      tick();
      k++;
    end
    check_val(tag, (done_cnt != n0), 1);
  endtask

  logic [7:0]  t1_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0]  t2_data [3] = '{8'hA5, 8'h5A, 8'hFF};
  logic [21:0] t2_raddr[3] = '{22'h3FFFFE, 22'h3FFFFF, 22'h000000};

  initial begin
    int b0, w0, r0, d0, e0, x0, bc, k;

    // ---- reset state ----
    repeat (3) tick();
    check_val("rst_busy",    busy,      0);
    check_val("rst_done",    done,      0);
    check_val("rst_ndma_z",  nDMA,      1);
    check_val("rst_a_oe",    A_oe,      0);
    check_val("rst_rnw_oe",  RnW_oe,    0);
    check_val("rst_d_oe",    D_oe,      0);
    check_val("rst_ram_req", ram_req,   0);
    check_val("rst_ram_we",  ram_we,    0);
    check_val("rst_rnw",     RnW_out,   1);
    check_val("rst_a_out",   A_out,     0);
    check_val("rst_d_out",   D_out,     0);
    check_val("rst_ram_adr", ram_addr,  0);
    check_val("rst_ram_wd",  ram_wdata, 0);
    RES = 1'b0;
    repeat (20) tick();

    // ---- read transfer: C64 -> DRAM ----
    b0 = bus_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = doe_cnt;
    start_xfer(1'b0, 16'hC000, 22'h001230, 16'd4);
    check_val("t1_ndma_low", nDMA, 0);
    check_val("t1_busy",     busy, 1);
    wait_done("t1_done_seen", 2000);
    tick(); tick();
    check_val("t1_done_once", done_cnt - d0, 1);
    check_val("t1_busy_end",  busy, 0);
    check_val("t1_ndma_rel",  nDMA, 1);
    check_val("t1_nbus",      bus_cnt - b0, 4);
    check_val("t1_nwr",       wr_cnt - w0, 4);
    check_val("t1_no_doe",    doe_cnt - e0, 0);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t1_a%0d", i),   bus_addr[b0+i], 16'hC000 + 16'(i));
      check_val($sformatf("t1_rnw%0d", i), bus_rnw[b0+i],  1);
      check_val($sformatf("t1_wa%0d", i),  wr_addr[w0+i],  22'h001230 + 22'(i));
      check_val($sformatf("t1_wd%0d", i),  wr_data[w0+i],  t1_data[i]);
    end
    check_val("t1_ndma_track", ndma_bad, 0);

    // ---- write transfer: DRAM -> C64, DRAM address wraps ----
    repeat (5) tick();
    b0 = bus_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = doe_cnt; x0 = doe_early;
    start_xfer(1'b1, 16'h0400, 22'h3FFFFE, 16'd3);
    wait_done("t2_done_seen", 2000);
    tick();
    check_val("t2_done_once", done_cnt - d0, 1);
    check_val("t2_nbus",      bus_cnt - b0, 3);
    check_val("t2_nrd",       rd_cnt - r0, 3);
    check_val("t2_doe_cnt",   doe_cnt - e0, 12);
    check_val("t2_doe_window", doe_early - x0, 0);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t2_ra%0d", i),  rd_addr[r0+i],  t2_raddr[i]);
      check_val($sformatf("t2_a%0d", i),   bus_addr[b0+i], 16'h0400 + 16'(i));
      check_val($sformatf("t2_rnw%0d", i), bus_rnw[b0+i],  0);
      check_val($sformatf("t2_d%0d", i),   bus_dout[b0+i], t2_data[i]);
    end

    // ---- BA stall for 3 PHI2 cycles mid-transfer ----
    repeat (5) tick();
    b0 = bus_cnt; w0 = wr_cnt; d0 = done_cnt;
    start_xfer(1'b0, 16'h2000, 22'h000100, 16'd3);
    k = 0;
    while (bus_cnt == b0 && k < 2000) begin tick(); k++; end
    k = 0;
    while (A_oe && k < 2000) begin tick(); k++; end
    check_val("t3_first_cycle", (bus_cnt - b0 == 1) && !A_oe, 1);
    BA = 1'b0;
    bc = bus_cnt;
    repeat (24) tick();
    check_val("t3_stall_nobus", bus_cnt, bc);
    check_val("t3_stall_busy",  busy, 1);
    check_val("t3_stall_nwr",   wr_cnt - w0, 1);
    BA = 1'b1;
    wait_done("t3_done_seen", 2000);
    tick();
    check_val("t3_nbus", bus_cnt - b0, 3);
    check_val("t3_nwr",  wr_cnt - w0, 3);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t3_a%0d", i),  bus_addr[b0+i], 16'h2000 + 16'(i));
      check_val($sformatf("t3_wa%0d", i), wr_addr[w0+i],  22'h000100 + 22'(i));
      check_val($sformatf("t3_wd%0d", i), wr_data[w0+i],  t1_data[i]);
    end

    // ---- len=0 (65536 bytes) from 0xFFFF: address wrap, then RES during D_oe ----
    repeat (5) tick();
    b0 = bus_cnt; r0 = rd_cnt; d0 = done_cnt;
    start_xfer(1'b1, 16'hFFFF, 22'h000010, 16'd0);
    k = 0;
    while ((bus_cnt - b0) < 3 && k < 3000) begin tick(); k++; end
    check_val("t4_three_cycles", bus_cnt - b0, 3);
    check_val("t4_a0",   bus_addr[b0],   16'hFFFF);
    check_val("t4_a1",   bus_addr[b0+1], 16'h0000);
    check_val("t4_a2",   bus_addr[b0+2], 16'h0001);
    check_val("t4_d0",   bus_dout[b0],   8'h2C);
    check_val("t4_d1",   bus_dout[b0+1], 8'h2D);
    check_val("t4_ra2",  rd_addr[r0+2],  22'h000012);
    check_val("t4_busy", busy, 1);
    check_val("t4_no_done", done_cnt - d0, 0);
    k = 0;
    while (!D_oe && k < 200) begin tick(); k++; end
    check_val("t5_doe_before_res", D_oe, 1);
    RES = 1'b1;
    #1;
    check_val("t5_a_oe",   A_oe,    0);
    check_val("t5_rnw_oe", RnW_oe,  0);
    check_val("t5_d_oe",   D_oe,    0);
    check_val("t5_ndma_z", nDMA,    1);
    check_val("t5_busy",   busy,    0);
    check_val("t5_ramreq", ram_req, 0);
    check_val("t5_d2",     bus_dout[b0+2], 8'h2E);
    repeat (4) tick();
    RES = 1'b0;
    repeat (3) tick();
    check_val("t5_no_done", done_cnt - d0, 0);

    // ---- start after RES is accepted ----
    b0 = bus_cnt; w0 = wr_cnt; d0 = done_cnt;
    start_xfer(1'b0, 16'h3005, 22'h2ABCDE, 16'd1);
    check_val("t5b_busy", busy, 1);
    wait_done("t5b_done_seen", 2000);
    tick();
    check_val("t5b_nbus", bus_cnt - b0, 1);
    check_val("t5b_a",    bus_addr[b0], 16'h3005);
    check_val("t5b_wa",   wr_addr[w0],  22'h2ABCDE);
    check_val("t5b_wd",   wr_data[w0],  8'h66);
    check_val("t5b_busy_end", busy, 0);

`ifdef CRAM_DMA_IRQ_EN
    // ---- IRQ: held after done until irq_ack ----
    repeat (5) tick();
    check_val("irq_held", nIRQ_out, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    check_val("irq_cleared", nIRQ_out, 1);
    // irq_ack coincident with done: done wins
    start_xfer(1'b0, 16'h4000, 22'h000200, 16'd1);
    k = 0;
    while (!done && k < 2000) begin tick(); k++; end
    check_val("irq_done_seen", done, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    check_val("irq_coincident", nIRQ_out, 0);
`endif

    check_val("ram_stable",  ram_unstable, 0);
    check_val("ndma_track",  ndma_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
